calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 EXEC_LAT, 2, number of wait cycles in EXEC before result load; legal range 1..15, held in a 4-bit counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_valid  input  1  single-cycle strobe; key_type/key_code are valid when high.
REQ-005 key_type  input  2  00 digit, 01 operator, 10 equals, 11 clear.
REQ-006 key_code  input  5  digit value or operator code; passed to the registers externally, not stored here.
REQ-007 en_a  output  1  load strobe for the 5-bit operand A register.
REQ-008 en_op  output  1  load strobe for the 5-bit opcode register.
REQ-009 en_b  output  1  load strobe for the 5-bit operand B register.
REQ-010 en_res  output  1  load strobe for the 5-bit result register.
REQ-011 data_sel  output  2  A-register source: 00 key_code, 01 result feedback.
REQ-012 busy  output  1  high while state is EXEC.
REQ-013 err  output  1  sticky sequence-error flag.
REQ-014 state  output  3  current state encoding.

Function
REQ-015 States: IDLE=0, GOT_A=1, GOT_OP=2, GOT_B=3, EXEC=4, SHOW=5; codes 6 and 7 return to IDLE on the next edge.
REQ-016 All outputs are registered; a strobe fires in the cycle after key_valid is sampled and is exactly one cycle wide.
REQ-017 data_sel is 00 except in a cycle where en_a loads from result feedback.
REQ-018 key_valid low leaves the state unchanged and all strobes low.
REQ-019 IDLE: digit -> en_a, GOT_A; operator -> ignored; equals -> err set.
REQ-020 GOT_A: digit -> en_a (overwrite), stay; operator -> en_op, GOT_OP; equals -> ignored.
REQ-021 GOT_OP: operator -> en_op (replace), stay; digit -> en_b, GOT_B; equals -> err set.
REQ-022 GOT_B: digit -> en_b (overwrite), stay; equals -> EXEC with counter loaded with EXEC_LAT; operator -> err set.
REQ-023 EXEC: counter decrements each cycle; at zero, en_res pulses and the state moves to SHOW; en_res is high exactly EXEC_LAT+1 cycles after the cycle equals was presented.
REQ-024 EXEC: digit, operator and equals keys are dropped without error.
REQ-025 SHOW: digit -> en_a, GOT_A; equals -> ignored; operator -> see REQ-031/032.
REQ-026 Clear key in any state, including EXEC and err: state IDLE, err cleared, no strobe in the following cycle.
REQ-027 While err=1, only clear is accepted; the state holds and no strobes fire.
REQ-028 At most one strobe is asserted per cycle, except the chain case in REQ-031.

Reset
REQ-029 When reset is asserted: state=IDLE, counter=0, all strobes 0, data_sel=00, busy=0, err=0, immediately and without waiting for clk.
REQ-030 Reset asserted during EXEC cancels the pending en_res; no strobe fires on the first edge after reset deasserts.

Configuration
REQ-031 With CALC_SEQUENCER_CHAIN_EN defined, an operator in SHOW pulses en_a with data_sel=01 and en_op in the same cycle, then moves to GOT_OP.
REQ-032 Without CALC_SEQUENCER_CHAIN_EN, an operator in SHOW is ignored and data_sel is constantly 00.

Verification
REQ-033 Key sequence digit 3, op 1, digit 4, equals with EXEC_LAT=2 -> en_a, en_op, en_b each one cycle after their keys; busy for 3 cycles; en_res 3 cycles after equals; state=5.
REQ-034 Equals in IDLE, then digit 7 -> err=1 and no en_a; then clear -> err=0, state=0; digit 7 -> en_a.
REQ-035 Reset pulse 1 cycle after equals (EXEC_LAT=4) -> en_res never asserts; state=0 asynchronously.
REQ-036 Keys presented while busy=1 -> no strobes; en_res still arrives at the same cycle.
REQ-037 SHOW then operator 2 -> with CHAIN_EN: en_a+en_op together with data_sel=01 and state=2; without CHAIN_EN: no strobe and state=5.
REQ-038 Force state=6 via reset-free backdoor -> state=0 one edge later with no strobes.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Key-entry and register-strobe bundle for calc_sequencer.
// master = key source / strobe consumer, slave = the sequencer itself.
interface calc_sequencer_if;
  // Handshake: key_valid is a one-cycle strobe with no backpressure (no ready);
  // key_type/key_code are meaningful only while key_valid is high, and a key
  // that is not accepted in the current state is dropped.
  logic       key_valid;
  logic [1:0] key_type;
  logic [4:0] key_code;
  logic       en_a;
  logic       en_op;
  logic       en_b;
  logic       en_res;
  logic [1:0] data_sel;
  logic       busy;
  logic       err;
  logic [2:0] state;

  modport master (
    output key_valid, key_type, key_code,
    input  en_a, en_op, en_b, en_res, data_sel, busy, err, state
  );

  modport slave (
    input  key_valid, key_type, key_code,
    output en_a, en_op, en_b, en_res, data_sel, busy, err, state
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: turns key strobes into one-cycle register load strobes.
// Define CALC_SEQUENCER_CHAIN_EN to let an operator in SHOW reuse the result as operand A.
module calc_sequencer #(
  parameter int EXEC_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  calc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_OP = 3'd2,
    S_GOT_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_SHOW   = 3'd5
  } state_e;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLR   = 2'b11;
  localparam logic [1:0] SEL_KEY = 2'b00;
  localparam logic [3:0] LAT     = 4'(EXEC_LAT);

  // state_q is a plain vector so the unused codes 6/7 are representable.
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       en_a_q, en_a_d;
  logic       en_op_q, en_op_d;
  logic       en_b_q, en_b_d;
  logic       en_res_q, en_res_d;
  logic [1:0] data_sel_q, data_sel_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic key_dig, key_op, key_eq, key_clr;
  logic unused_key_code;

  assign key_dig = bus.key_valid && (bus.key_type == K_DIGIT);
  assign key_op  = bus.key_valid && (bus.key_type == K_OP);
  assign key_eq  = bus.key_valid && (bus.key_type == K_EQ);
  assign key_clr = bus.key_valid && (bus.key_type == K_CLR);
  assign unused_key_code = ^bus.key_code;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    en_a_d     = 1'b0;
    en_op_d    = 1'b0;
    en_b_d     = 1'b0;
    en_res_d   = 1'b0;
    data_sel_d = SEL_KEY;
    if (key_clr) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      err_d   = 1'b0;
    end else if (state_q > S_SHOW) begin
      state_d = S_IDLE;
    end else if (state_q == S_EXEC) begin
      // en_res fires as the counter reaches zero; EXEC is left one cycle later.
      if (cnt_q == 4'd0) begin
        state_d = S_SHOW;
      end else begin
        cnt_d    = cnt_q - 4'd1;
        en_res_d = (cnt_q == 4'd1);
      end
    end else if (!err_q) begin
      case (state_q)
        S_IDLE: begin
          if (key_dig) begin
            en_a_d  = 1'b1;
            state_d = S_GOT_A;
          end else if (key_eq) begin
            err_d = 1'b1;
          end
        end
        S_GOT_A: begin
          if (key_dig) begin
            en_a_d = 1'b1;
          end else if (key_op) begin
            en_op_d = 1'b1;
            state_d = S_GOT_OP;
          end
        end
        S_GOT_OP: begin
          if (key_op) begin
            en_op_d = 1'b1;
          end else if (key_dig) begin
            en_b_d  = 1'b1;
            state_d = S_GOT_B;
          end else if (key_eq) begin
            err_d = 1'b1;
          end
        end
        S_GOT_B: begin
          if (key_dig) begin
            en_b_d = 1'b1;
          end else if (key_eq) begin
            state_d = S_EXEC;
            cnt_d   = LAT;
          end else if (key_op) begin
            err_d = 1'b1;
          end
        end
        S_SHOW: begin
          if (key_dig) begin
            en_a_d  = 1'b1;
            state_d = S_GOT_A;
          end
`ifdef CALC_SEQUENCER_CHAIN_EN
          else if (key_op) begin
            en_a_d     = 1'b1;
            en_op_d    = 1'b1;
            data_sel_d = 2'b01;
            state_d    = S_GOT_OP;
          end
`endif
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      en_a_q     <= 1'b0;
      en_op_q    <= 1'b0;
      en_b_q     <= 1'b0;
      en_res_q   <= 1'b0;
      data_sel_q <= SEL_KEY;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_a_q     <= en_a_d;
      en_op_q    <= en_op_d;
      en_b_q     <= en_b_d;
      en_res_q   <= en_res_d;
      data_sel_q <= data_sel_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.en_a     = en_a_q;
  assign bus.en_op    = en_op_q;
  assign bus.en_b     = en_b_q;
  assign bus.en_res   = en_res_q;
  assign bus.data_sel = data_sel_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random key streams against a cycle-indexed model.
module tb_calc_sequencer;

  localparam int LAT = 2;
  localparam int W   = 11;
  localparam logic [1:0] K_DIG = 2'd0;
  localparam logic [1:0] K_OP  = 2'd1;
  localparam logic [1:0] K_EQ  = 2'd2;
  localparam logic [1:0] K_CLR = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase number, error flag, current cycle index, last EXEC output cycle.
  int m_st       = 0;
  bit m_err      = 1'b0;
  int m_cyc      = 0;
  int m_exec_end = 0;

  calc_sequencer_if bus();

  calc_sequencer #(.EXEC_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] obs_word();
    return {bus.state, bus.err, bus.busy, bus.data_sel,
            bus.en_res, bus.en_b, bus.en_op, bus.en_a};
  endfunction

  // Next-cycle outputs from the current phase and the key presented this cycle.
  task automatic model_step(input bit v, input logic [1:0] t, output logic [W-1:0] e);
    int ns;
    bit a, o, b, r;
    logic [1:0] ds;
    ns = m_st; a = 0; o = 0; b = 0; r = 0; ds = 2'b00;
    if (v && t == K_CLR) begin
      ns = 0;
      m_err = 1'b0;
    end else if (m_st > 5) begin
      ns = 0;
    end else if (m_st == 4) begin
      if (m_cyc + 1 <= m_exec_end) r = (m_cyc + 1 == m_exec_end);
      else ns = 5;
    end else if (v && !m_err) begin
      case (m_st)
        0: if (t == K_DIG) begin a = 1; ns = 1; end
           else if (t == K_EQ) m_err = 1'b1;
        1: if (t == K_DIG) a = 1;
           else if (t == K_OP) begin o = 1; ns = 2; end
        2: if (t == K_OP) o = 1;
           else if (t == K_DIG) begin b = 1; ns = 3; end
           else if (t == K_EQ) m_err = 1'b1;
        3: if (t == K_DIG) b = 1;
           else if (t == K_EQ) begin ns = 4; m_exec_end = m_cyc + LAT + 1; end
           else if (t == K_OP) m_err = 1'b1;
        5: if (t == K_DIG) begin a = 1; ns = 1; end
`ifdef CALC_SEQUENCER_CHAIN_EN
           else if (t == K_OP) begin a = 1; o = 1; ds = 2'b01; ns = 2; end
`endif
        default: ;
      endcase
    end
    m_st = ns;
    m_cyc++;
    e = {3'(ns), m_err, (ns == 4), ds, r, b, o, a};
  endtask

  task automatic step(input bit v, input logic [1:0] t);
    logic [W-1:0] e;
    @(negedge clk);
    bus.key_valid = v;
    bus.key_type  = t;
    bus.key_code  = 5'($urandom_range(0, 31));
    model_step(v, t, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq("cycle", 32'(obs_word()), 32'(exp_q.pop_front()));
    bus.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_async", 32'(obs_word()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_st  = 0;
    m_err = 1'b0;
  endtask

  initial begin
    int busy_n;
    int res_k;
    int r;
    bus.key_valid = 1'b0;
    bus.key_type  = 2'b00;
    bus.key_code  = 5'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", 32'(obs_word()), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic calculation: digit, op, digit, equals, with keys dropped while busy.
    step(1, K_DIG); check_eq("en_a_digit", 32'(bus.en_a), 32'd1);
    step(1, K_OP);  check_eq("en_op_op", 32'(bus.en_op), 32'd1);
    step(1, K_DIG); check_eq("en_b_digit", 32'(bus.en_b), 32'd1);
    step(1, K_EQ);
    busy_n = int'(bus.busy);
    res_k  = bus.en_res ? 1 : 0;
    for (int k = 2; k <= LAT + 2; k++) begin
      step(1, 2'($urandom_range(0, 2)));
      busy_n += int'(bus.busy);
      if (bus.en_res) res_k = k;
    end
    check_eq("busy_cycles", 32'(busy_n), 32'(LAT + 1));
    check_eq("res_cycle", 32'(res_k), 32'(LAT + 1));
    check_eq("show_state", 32'(bus.state), 32'd5);

    // Operator in SHOW.
    step(1, K_OP);
`ifdef CALC_SEQUENCER_CHAIN_EN
    check_eq("chain_strobes", 32'({bus.en_a, bus.en_op, bus.data_sel}), 32'b1101);
    check_eq("chain_state", 32'(bus.state), 32'd2);
`else
    check_eq("show_op_strobes", 32'({bus.en_a, bus.en_op, bus.data_sel}), 32'b0000);
    check_eq("show_op_state", 32'(bus.state), 32'd5);
`endif

    // Error path and recovery through clear.
    step(1, K_CLR); check_eq("clr_state", 32'(bus.state), 32'd0);
    step(1, K_EQ);  check_eq("err_set", 32'(bus.err), 32'd1);
    step(1, K_DIG); check_eq("err_blocks_a", 32'({bus.err, bus.en_a}), 32'b10);
    step(1, K_CLR); check_eq("err_cleared", 32'({bus.err, bus.state}), 32'd0);
    step(1, K_DIG); check_eq("en_a_after_clr", 32'(bus.en_a), 32'd1);

    // Reset one cycle after equals cancels the result load.
    step(1, K_OP);
    step(1, K_DIG);
    step(1, K_EQ);
    step(0, K_DIG);
    do_reset();
    for (int k = 0; k < LAT + 2; k++) begin
      step(0, K_DIG);
      check_eq("no_res_after_rst", 32'({bus.en_res, bus.state}), 32'd0);
    end

    // Unused state code falls back to IDLE.
    step(1, K_DIG);
    #1;
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    check_eq("bd_forced", 32'(bus.state), 32'd6);
    m_st = 6;
    step(0, K_DIG);
    check_eq("bd_recover", 32'({bus.state, bus.en_a, bus.en_op, bus.en_b, bus.en_res}), 32'd0);

    // Random key streams.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      step($urandom_range(0, 9) < 7, (r == 0) ? K_CLR : 2'(r % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
